// File: rtl/if_id_pkg.sv
// Package: if_id_pkg
// Shared types and constants for the IF->ID pipeline register.
//   occ_e      occupancy of the register pair {EMPTY, ONE, TWO}
//   payload_t  one fetched beat {pc, instr} at the default widths
//   IF_ID_NOP  instruction presented while no beat is valid (addi x0,x0,0)
package if_id_pkg;

    localparam int          IF_ID_XLEN = 32;
    localparam int          IF_ID_ILEN = 32;
    localparam logic [31:0] IF_ID_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [IF_ID_XLEN-1:0] pc;
        logic [IF_ID_ILEN-1:0] instr;
    } payload_t;

endpackage

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Module: sat_counter
// Enable-increment counter that sticks at all-ones.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (count -> 0)
//   en     increment this cycle
//   cnt    current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Module: if_id_pipe_reg
// IF->ID pipeline register with valid/ready handshake and a one-deep skid
// slot, so fetch sees a registered in_ready and decode back-pressure never
// loses a beat. One beat/cycle when decode is not stalling.
// Optional feature: define IF_ID_PERF_EN to add stall/flush perf counters.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch handshake (in_ready is registered)
//   instr_i, pc_i         fetched beat
//   flush_i               redirect: drop everything held and the incoming beat
//   out_valid/out_ready   decode handshake
//   instr_o, pc_o         beat to decode (NOP / 0 while out_valid=0)
//   stall_cnt_o           [IF_ID_PERF_EN] cycles with out_valid & !out_ready
//   flush_cnt_o           [IF_ID_PERF_EN] cycles with flush_i asserted
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int              XLEN  = IF_ID_XLEN,
    parameter int              ILEN  = IF_ID_ILEN,
    parameter logic [ILEN-1:0] NOP   = ILEN'(IF_ID_NOP),
    parameter int              CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } slot_t;

    localparam slot_t BUBBLE = '{pc: '0, instr: NOP};

    occ_e  state;
    slot_t out_slot;
    slot_t skid_slot;
    slot_t in_beat;
    logic  acc;
    logic  rel;

    assign in_beat = '{pc: pc_i, instr: instr_i};
    assign acc     = in_valid & in_ready;
    assign rel     = out_valid & out_ready;

    // out_valid and in_ready are kept as registers alongside the state so
    // neither output has a combinational path from any input.
    // The output slot is reloaded with BUBBLE whenever it empties, which is
    // what makes instr_o/pc_o read NOP/0 while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_slot  <= BUBBLE;
            skid_slot <= BUBBLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush_i) begin
            // Flush beats any same-cycle accept: the incoming beat is dropped.
            state     <= EMPTY;
            out_slot  <= BUBBLE;
            skid_slot <= BUBBLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        out_slot  <= in_beat;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        out_slot <= in_beat;
                    end else if (acc) begin
                        // Decode stalled: park the new beat behind the output.
                        skid_slot <= in_beat;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (rel) begin
                        out_slot  <= BUBBLE;
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a release can happen.
                    if (rel) begin
                        out_slot <= skid_slot;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_slot  <= BUBBLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign instr_o = out_slot.instr;
    assign pc_o    = out_slot.pc;

`ifdef IF_ID_PERF_EN
    // Counters only see reset; flush is an event they count, not a clear.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_valid & ~out_ready),
        .cnt   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_i),
        .cnt   (flush_cnt_o)
    );
`endif

endmodule
